// File: rtl/func_sweep_ctrl.sv
// Built-in self-check sequencer: sweeps all 16 {A,B,C,D} vectors through a 4-input
// function block and compares O against a golden minterm mask. Option: FUNC_SWEEP_STOP_ON_FAIL_EN.
module func_sweep_ctrl #(
    parameter logic [15:0] MINTERM_MASK  = 16'hA5F5,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       func_i,
    output logic [3:0] vec_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [4:0] err_cnt_o,
    output logic       fail_valid_o,
    output logic [3:0] first_fail_o
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] settle_cnt, settle_cnt_n;
    logic [3:0] vec_n;
    logic       busy_n, done_n, pass_n, fail_valid_n;
    logic [4:0] err_cnt_n;
    logic [3:0] first_fail_n;
    logic       mismatch;

    assign mismatch = (state == SAMPLE) && (func_i != MINTERM_MASK[vec_o]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_n and no latch is inferred.
        state_n = state;
        unique case (state)
            IDLE, DONE: if (start_i) state_n = DRIVE;
            DRIVE:      if (settle_cnt == SETTLE_LAST) state_n = SAMPLE;
            SAMPLE: begin
`ifdef FUNC_SWEEP_STOP_ON_FAIL_EN
                if (mismatch || vec_o == 4'd15) state_n = DONE;
                else                            state_n = DRIVE;
`else
                if (vec_o == 4'd15) state_n = DONE;
                else                state_n = DRIVE;
`endif
            end
            default:    state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, steered by the current state.
    always_comb begin
        vec_n        = vec_o;
        busy_n       = busy_o;
        done_n       = done_o;
        pass_n       = pass_o;
        err_cnt_n    = err_cnt_o;
        fail_valid_n = fail_valid_o;
        first_fail_n = first_fail_o;
        settle_cnt_n = settle_cnt;
        unique case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    vec_n        = 4'd0;
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    pass_n       = 1'b0;
                    err_cnt_n    = 5'd0;
                    fail_valid_n = 1'b0;
                    first_fail_n = 4'd0;
                    settle_cnt_n = 4'd0;
                end
            end
            DRIVE: begin
                settle_cnt_n = (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_o < 5'd16) err_cnt_n = err_cnt_o + 5'd1;
                    if (!fail_valid_o) begin
                        first_fail_n = vec_o;
                        fail_valid_n = 1'b1;
                    end
                end
                if (state_n == DONE) begin
                    busy_n = 1'b0;
                    done_n = 1'b1;
                    pass_n = (err_cnt_n == 5'd0);
                end else begin
                    vec_n = vec_o + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_o        <= 4'd0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            err_cnt_o    <= 5'd0;
            fail_valid_o <= 1'b0;
            first_fail_o <= 4'd0;
            settle_cnt   <= 4'd0;
        end else begin
            vec_o        <= vec_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
            pass_o       <= pass_n;
            err_cnt_o    <= err_cnt_n;
            fail_valid_o <= fail_valid_n;
            first_fail_o <= first_fail_n;
            settle_cnt   <= settle_cnt_n;
        end
    end

endmodule
